i2c_eeprom_master: RTL and testbench

- Bit-level I2C master engine for AT24C02 single-byte transfers.
- Sits directly downstream of the I2C AXI4-Lite register interface and consumes its i2c_data0, i2c_data1 and i2c_start outputs.
- Drives open-drain SCL/SDA and returns i2c_data2 (read byte plus status) and i2c_busy to the register interface.
- Supports byte write and random read; no page mode and no clock stretching.

---
 rtl/i2c_eeprom_master_if.sv | 22 ++
 rtl/i2c_eeprom_master.sv | 166 ++++++++++++++++
 tb/tb_i2c_eeprom_master.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_eeprom_master_if.sv
// Register-side and pad-side signals of the AT24C02 I2C engine.
// master: the bit engine; slave: register block plus pads.
interface i2c_eeprom_master_if;
    logic [31:0] i2c_data0;
    logic [31:0] i2c_data1;
    logic        i2c_start;
    logic [31:0] i2c_data2;
    logic        i2c_busy;
    logic        scl_oen;
    logic        sda_oen;
    logic        sda_i;

    modport master (
        input  i2c_data0, i2c_data1, i2c_start, sda_i,
        output i2c_data2, i2c_busy, scl_oen, sda_oen
    );

    modport slave (
        output i2c_data0, i2c_data1, i2c_start, sda_i,
        input  i2c_data2, i2c_busy, scl_oen, sda_oen
    );
endinterface

// File: rtl/i2c_eeprom_master.sv
// Bit-level I2C master for AT24C02 byte write and random read.
// Each bus slot is four quarter periods of CLK_DIV clocks.
module i2c_eeprom_master #(
    parameter int CLK_DIV = 125
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_aresetn,
    i2c_eeprom_master_if.master        bus
);
    typedef enum logic [2:0] {
        IDLE, START, TX_BYTE, RX_ACK,
        RSTART, RX_BYTE, TX_NACK, STOP
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t      r_state;
    logic [15:0] r_div;
    logic [1:0]  r_q;
    logic [2:0]  r_bit;
    logic [1:0]  r_byte;
    logic [7:0]  r_sh;
    logic [6:0]  r_addr;
    logic [7:0]  r_mem;
    logic [7:0]  r_wdata;
    logic        r_rd;
    logic        r_busy;
    logic        r_scl;
    logic        r_sda;
    logic [9:0]  r_d2;
    logic        w_tick;
    logic        w_unused;

    assign w_tick        = r_busy && (r_div == DIV_LAST);
    assign bus.i2c_data2 = {22'd0, r_d2};
    assign bus.i2c_busy  = r_busy;
    assign bus.scl_oen   = r_scl;
    assign bus.sda_oen   = r_sda;
    assign w_unused      = ^{bus.i2c_data0[31:17], bus.i2c_data0[0],
                             bus.i2c_data1[31:8]};

    // Sequencer: outputs for each quarter are loaded on the tick that starts it.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_q     <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_sh    <= '0;
            r_addr  <= '0;
            r_mem   <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
            r_d2    <= '0;
        end else if (!r_busy) begin
            if (bus.i2c_start) begin
                r_busy     <= 1'b1;
                r_state    <= START;
                r_q        <= '0;
                r_div      <= '0;
                r_bit      <= '0;
                r_byte     <= '0;
                r_addr     <= bus.i2c_data0[7:1];
                r_mem      <= bus.i2c_data0[15:8];
                r_rd       <= bus.i2c_data0[16];
                r_wdata    <= bus.i2c_data1[7:0];
                r_d2[9:8]  <= 2'b00;
            end
        end else begin
            r_div <= w_tick ? 16'd0 : r_div + 16'd1;
            if (w_tick) begin
                r_q <= r_q + 2'd1;
                if (r_q != 2'd3) begin
                    // Within a slot only SCL toggles, plus the START/STOP SDA edges.
                    r_scl <= (r_q != 2'd2) || (r_state == STOP);
                    if ((r_state == START || r_state == RSTART) && r_q == 2'd1)
                        r_sda <= 1'b0;
                    if (r_state == STOP && r_q == 2'd2)
                        r_sda <= 1'b1;
                    if (r_q == 2'd2) begin
                        if (r_state == RX_ACK && bus.sda_i)
                            r_d2[8] <= 1'b1;
                        if (r_state == RX_BYTE)
                            r_sh <= {r_sh[6:0], bus.sda_i};
                    end
                end else begin
                    r_scl <= 1'b0;
                    r_sda <= 1'b1;
                    case (r_state)
                        START: begin
                            r_state <= TX_BYTE;
                            r_bit   <= 3'd7;
                            r_sh    <= {r_addr, 1'b0};
                            r_sda   <= r_addr[6];
                        end
                        TX_BYTE: begin
                            if (r_bit == 3'd0) begin
                                r_state <= RX_ACK;
                            end else begin
                                r_bit <= r_bit - 3'd1;
                                r_sh  <= {r_sh[6:0], 1'b0};
                                r_sda <= r_sh[6];
                            end
                        end
                        RX_ACK: begin
                            if (r_d2[8]) begin
                                r_state <= STOP;
                                r_sda   <= 1'b0;
                            end else if (r_byte == 2'd0) begin
                                r_byte  <= 2'd1;
                                r_state <= TX_BYTE;
                                r_bit   <= 3'd7;
                                r_sh    <= r_mem;
                                r_sda   <= r_mem[7];
                            end else if (r_byte == 2'd1 && !r_rd) begin
                                r_byte  <= 2'd2;
                                r_state <= TX_BYTE;
                                r_bit   <= 3'd7;
                                r_sh    <= r_wdata;
                                r_sda   <= r_wdata[7];
                            end else if (r_byte == 2'd1) begin
                                r_byte  <= 2'd2;
                                r_state <= RSTART;
                            end else if (r_rd) begin
                                r_state <= RX_BYTE;
                                r_bit   <= 3'd7;
                            end else begin
                                r_state <= STOP;
                                r_sda   <= 1'b0;
                            end
                        end
                        RSTART: begin
                            r_state <= TX_BYTE;
                            r_bit   <= 3'd7;
                            r_sh    <= {r_addr, 1'b1};
                            r_sda   <= r_addr[6];
                        end
                        RX_BYTE: begin
                            if (r_bit == 3'd0) begin
                                r_state   <= TX_NACK;
                                r_d2[7:0] <= r_sh;
                            end else begin
                                r_bit <= r_bit - 3'd1;
                            end
                        end
                        TX_NACK: begin
                            r_state <= STOP;
                            r_sda   <= 1'b0;
                        end
                        default: begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_d2[9] <= (r_state == STOP);
                            r_scl   <= 1'b1;
                            r_sda   <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_eeprom_master.sv
// Bench for i2c_eeprom_master: quarter-level bus model, slave model,
// protocol monitor, directed cases and randomized transfers.
module tb_i2c_eeprom_master;
    localparam int DIV = 4;

    logic clk;
    logic rst_n;
    bit   slv;

    i2c_eeprom_master_if bus ();

    i2c_eeprom_master #(.CLK_DIV(DIV)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .bus           (bus)
    );

    assign bus.sda_i = bus.sda_oen & slv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fall   = 0;
    int n_rise   = 0;

    bit [1:0] eq[$];
    bit       sq[$];
    bit [7:0] lo;
    bit [31:0] exp_d2;
    int       exp_rs;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void put_slot(bit [1:0] a, bit [1:0] b,
                                     bit [1:0] c, bit [1:0] d, bit s);
        eq.push_back(a);
        eq.push_back(b);
        eq.push_back(c);
        eq.push_back(d);
        sq.push_back(s);
    endfunction

    function automatic void put_bit(bit m, bit s);
        put_slot({1'b0, m}, {1'b1, m}, {1'b1, m}, {1'b0, m}, s);
    endfunction

    function automatic bit put_byte(bit [7:0] b, bit nack);
        for (int i = 7; i >= 0; i--) put_bit(b[i], 1'b1);
        put_bit(1'b1, nack);
        return nack;
    endfunction

    function automatic void build(bit [6:0] a, bit [7:0] m, bit rd,
                                  bit [7:0] wd, bit [7:0] rdat, int nk);
        bit bad;
        eq.delete();
        sq.delete();
        exp_rs = 0;
        put_slot(2'b11, 2'b11, 2'b10, 2'b00, 1'b1);
        bad = put_byte({a, 1'b0}, nk == 0);
        if (!bad) bad = put_byte(m, nk == 1);
        if (!bad && !rd) bad = put_byte(wd, nk == 2);
        if (!bad && rd) begin
            put_slot(2'b01, 2'b11, 2'b10, 2'b00, 1'b1);
            exp_rs = 1;
            bad = put_byte({a, 1'b1}, nk == 2);
            if (!bad) begin
                for (int i = 7; i >= 0; i--) put_bit(1'b1, rdat[i]);
                put_bit(1'b1, 1'b1);
                lo = rdat;
            end
        end
        put_slot(2'b00, 2'b10, 2'b10, 2'b11, 1'b1);
        exp_d2 = {22'd0, 1'b1, bad, lo};
    endfunction

    task automatic run_txn(input bit [6:0] a, input bit [7:0] m,
                           input bit rd, input bit [7:0] wd,
                           input bit [7:0] rdat, input int nk,
                           input int mid_k, input int abort_k,
                           output int bcnt);
        int nq;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [2:0] ex;
        build(a, m, rd, wd, rdat, nk);
        nq = eq.size();
        d0 = $urandom;
        d0[16] = rd;
        d0[15:8] = m;
        d0[7:1] = a;
        d1 = $urandom;
        d1[7:0] = wd;
        bus.i2c_data0 = d0;
        bus.i2c_data1 = d1;
        n_fall = 0;
        n_rise = 0;
        bus.i2c_start = 1'b1;
        @(negedge clk);
        bus.i2c_start = 1'b0;
        bcnt = 0;
        for (int k = 0; k <= nq * DIV; k++) begin
            int s;
            s = k / (4 * DIV);
            slv = (s < sq.size()) ? sq[s] : 1'b1;
            bus.i2c_start = (k == mid_k);
            if (k == mid_k) begin
                bus.i2c_data0 = $urandom;
                bus.i2c_data1 = $urandom;
            end
            if (k == abort_k) begin
                #1 rst_n = 1'b0;
                #1;
                chk("reset busy", {31'd0, bus.i2c_busy}, 32'd0);
                chk("reset scl", {31'd0, bus.scl_oen}, 32'd1);
                chk("reset sda", {31'd0, bus.sda_oen}, 32'd1);
                chk("reset data2", bus.i2c_data2, 32'd0);
                lo = 8'd0;
                slv = 1'b1;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            ex = (k < nq * DIV) ? {1'b1, eq[k / DIV]} : 3'b011;
            chk($sformatf("busy/scl/sda k=%0d", k),
                {29'd0, bus.i2c_busy, bus.scl_oen, bus.sda_oen},
                {29'd0, ex});
            if (bus.i2c_busy) bcnt++;
            if (k < nq * DIV) @(negedge clk);
        end
        chk("data2", bus.i2c_data2, exp_d2);
        chk("start events", n_fall, 1 + exp_rs);
        chk("stop events", n_rise, 1);
    endtask

    bit prev_scl;
    bit prev_sda;
    bit hi_ok;
    int run;

    // Protocol monitor: START/STOP edge counts and SCL high/low times.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_scl = 1'b1;
            prev_sda = 1'b1;
            hi_ok = 1'b0;
            run = 0;
        end else begin
            if (bus.i2c_busy && prev_scl && bus.scl_oen &&
                prev_sda != bus.sda_oen) begin
                if (bus.sda_oen) n_rise++;
                else n_fall++;
            end
            if (bus.scl_oen != prev_scl) begin
                if (prev_scl && hi_ok)
                    chk("scl high time", run, 2 * DIV);
                if (!prev_scl && bus.i2c_busy)
                    chk("scl low time", run, 2 * DIV);
                hi_ok = bus.scl_oen && bus.i2c_busy;
                run = 1;
            end else begin
                run++;
            end
            if (!bus.i2c_busy) hi_ok = 1'b0;
            prev_scl = bus.scl_oen;
            prev_sda = bus.sda_oen;
        end
    end

    initial begin
        int bc;
        int r;
        int nk;
        int mk;
        rst_n = 1'b0;
        slv = 1'b1;
        lo = 8'd0;
        bus.i2c_start = 1'b0;
        bus.i2c_data0 = '0;
        bus.i2c_data1 = '0;
        repeat (3) @(negedge clk);
        chk("por busy", {31'd0, bus.i2c_busy}, 32'd0);
        chk("por scl", {31'd0, bus.scl_oen}, 32'd1);
        chk("por sda", {31'd0, bus.sda_oen}, 32'd1);
        chk("por data2", bus.i2c_data2, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(7'h50, 8'h3C, 1'b0, 8'h5A, 8'h00, -1, -1, -1, bc);
        chk("t1 quarters", eq.size(), 116);
        chk("t1 busy clocks", bc, 464);
        chk("t1 data2", bus.i2c_data2, 32'h200);
        repeat (3) @(negedge clk);

        run_txn(7'h50, 8'h10, 1'b1, 8'h00, 8'hC3, -1, -1, -1, bc);
        chk("t2 quarters", eq.size(), 156);
        chk("t2 busy clocks", bc, 624);
        chk("t2 data2", bus.i2c_data2, 32'h2C3);

        run_txn(7'h50, 8'h3C, 1'b0, 8'h5A, 8'h00, 1, -1, -1, bc);
        chk("t3 busy clocks", bc, 320);
        chk("t3 data2", bus.i2c_data2, 32'h3C3);
        repeat (2) @(negedge clk);

        run_txn(7'h50, 8'h3C, 1'b0, 8'h5A, 8'h00, -1, 40 * DIV, -1, bc);
        chk("t4 busy clocks", bc, 464);
        chk("t4 data2", bus.i2c_data2, 32'h2C3);
        repeat (2) @(negedge clk);

        run_txn(7'h48, 8'h77, 1'b0, 8'h11, 8'h00, -1, -1,
                12 * DIV + 1, bc);
        run_txn(7'h50, 8'h10, 1'b1, 8'h00, 8'h5E, -1, -1, -1, bc);
        chk("t5 busy clocks", bc, 624);
        chk("t5 data2", bus.i2c_data2, 32'h25E);

        for (int t = 0; t < 16; t++) begin
            r = $urandom_range(0, 5);
            nk = (r < 3) ? r : -1;
            mk = ($urandom_range(0, 3) == 0) ?
                 $urandom_range(1, 76 * DIV) : -1;
            run_txn(7'($urandom), 8'($urandom), 1'($urandom),
                    8'($urandom), 8'($urandom), nk, mk, -1, bc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
